// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory read streamer.
package mem_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SIZE_DEF  = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A read may only be issued if its word is guaranteed a slot in the 2-deep buffer.
    function automatic logic can_issue(input logic [1:0] occ, input logic pend, input logic pop);
        return ({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/mem_rd_streamer_if.sv
// Valid/ready stream bundle carried between the output buffer and the downstream port.
interface mem_rd_streamer_if
    import mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/stream_fifo.sv
// Two-entry output buffer; a written word is visible only from the following cycle.
module stream_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [1:0]         count,
    mem_rd_streamer_if.master  out
);
    logic [WIDTH-1:0] slot_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             pop_s;

    assign pop_s     = out.valid && out.ready;
    assign out.valid = (count_r != 2'd0);
    assign out.data  = slot_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_r[0] <= {WIDTH{1'b0}};
            slot_r[1] <= {WIDTH{1'b0}};
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            count_r   <= 2'd0;
        end else begin
            if (wr_en) begin
                slot_r[wr_ptr_r] <= wr_data;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, wr_en} - {1'b0, pop_s};
        end
    end
endmodule

// File: rtl/mem_rd_streamer.sv
// Streams a burst of consecutive SRAM words (wrapping address) out through a valid/ready port.
module mem_rd_streamer
    import mem_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int SIZE  = SIZE_DEF,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [AW-1:0]    base_addr_i,
    input  logic [AW:0]      len_i,
    output logic             mem_cenb_o,
    output logic             mem_wenb_o,
    output logic [AW-1:0]    mem_addr_o,
    input  logic [WIDTH-1:0] mem_q_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o
);
    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   ONE_L = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] TOP_A = AW'(SIZE - 1);

    mem_rd_streamer_if #(.WIDTH(WIDTH)) ob ();

    state_t        state_r, state_s;
    logic [AW-1:0] next_addr_r, last_addr_r, inc_addr_s;
    logic [AW:0]   rd_left_r, xfer_left_r;
    logic          pending_r, busy_r, done_r;
    logic          rd_s, pop_s, last_xfer_s, accept_s;
    logic [1:0]    occ_s;

    stream_fifo #(.WIDTH(WIDTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (pending_r),
        .wr_data (mem_q_i),
        .count   (occ_s),
        .out     (ob)
    );

    assign ob.ready    = ready_i;
    assign data_o      = ob.data;
    assign valid_o     = ob.valid;
    assign pop_s       = ob.valid && ready_i;
    assign accept_s    = (state_r == IDLE) && start_i;
    assign last_xfer_s = pop_s && (xfer_left_r == ONE_L);
    assign inc_addr_s  = (next_addr_r == TOP_A) ? {AW{1'b0}} : next_addr_r + ONE_A;

    assign mem_cenb_o  = ~rd_s;
    assign mem_wenb_o  = 1'b1;
    // The address bus shows the word being read, otherwise it parks on the last one read.
    assign mem_addr_o  = rd_s ? next_addr_r : last_addr_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

    // Next-state and read-issue decision
    always_comb begin
        state_s = state_r;
        rd_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i && (len_i != {(AW+1){1'b0}})) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                rd_s = can_issue(occ_s, pending_r, pop_s);
                if (rd_s && (rd_left_r == ONE_L)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (last_xfer_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, burst counters, address pointers and status flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            next_addr_r <= {AW{1'b0}};
            last_addr_r <= {AW{1'b0}};
            rd_left_r   <= {(AW+1){1'b0}};
            xfer_left_r <= {(AW+1){1'b0}};
            pending_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= rd_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= (accept_s && (len_i == {(AW+1){1'b0}})) ||
                         ((state_r == DRAIN) && last_xfer_s);
            if (accept_s) begin
                next_addr_r <= base_addr_i;
                rd_left_r   <= len_i;
                xfer_left_r <= len_i;
            end else begin
                if (rd_s) begin
                    next_addr_r <= inc_addr_s;
                    last_addr_r <= next_addr_r;
                    rd_left_r   <= rd_left_r - ONE_L;
                end
                if (pop_s) begin
                    xfer_left_r <= xfer_left_r - ONE_L;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_rd_streamer.sv
// Scoreboard bench: expected words/addresses queued at burst issue, checked by an independent monitor.
module tb_mem_rd_streamer;
    localparam int WIDTH = 32;
    localparam int SIZE  = 256;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    base = '0;
    logic [AW:0]      len = '0;
    logic             mem_cenb, mem_wenb, busy, done;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_q = '0;

    mem_rd_streamer_if #(.WIDTH(WIDTH)) s ();

    logic [WIDTH-1:0] mem_model [SIZE];
    logic [WIDTH-1:0] exp_q [$];
    int               addr_q [$];
    int total = 0, bad = 0;
    int ready_mode = 0;
    int cyc = 0, last_pop_cyc = 0, issued_n = 0, popped_n = 0;

    mem_rd_streamer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
        .mem_cenb_o(mem_cenb), .mem_wenb_o(mem_wenb), .mem_addr_o(mem_addr), .mem_q_i(mem_q),
        .data_o(s.data), .valid_o(s.valid), .ready_i(s.ready), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // SRAM behaviour: registered read data one cycle after an enabled read
    always @(posedge clk) if (!mem_cenb) mem_q <= mem_model[mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready pattern
    initial begin
        s.ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: s.ready = 1'b1;
                1: s.ready = ~s.ready;
                default: s.ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: read addresses, buffer bound, stream data order and hold stability
    initial begin
        logic             pop_now, held_v;
        logic [WIDTH-1:0] held_d;
        held_v = 1'b0; held_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                held_v = 1'b0;
            end else begin
                pop_now = s.valid && s.ready;
                if (held_v) begin
                    chk("hold_valid", s.valid, 1);
                    chk("hold_data", s.data, held_d);
                end
                if (!mem_cenb) begin
                    chk("wenb_high", mem_wenb, 1);
                    chk("read_expected", addr_q.size() != 0, 1);
                    if (addr_q.size() != 0) chk("rd_addr", mem_addr, addr_q.pop_front());
                    chk("no_overfill", (issued_n + 1 - popped_n - int'(pop_now)) <= 2, 1);
                    issued_n++;
                end
                if (pop_now) begin
                    chk("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("data", s.data, exp_q.pop_front());
                    popped_n++;
                    last_pop_cyc = cyc;
                end
                held_v = s.valid && !s.ready;
                held_d = s.data;
            end
        end
    end

    task automatic run_burst(input int b, input int l, input int mode, input int exp_first,
                             input int exp_done, input bit extra, input int abort_n);
        int k, first, done_cyc, a;
        bit got, aborted;
        logic done_busy;
        ready_mode = mode;
        for (int i = 0; i < l; i++) begin
            a = (b + i) % SIZE;
            addr_q.push_back(a);
            exp_q.push_back(mem_model[a]);
        end
        @(posedge clk); #1;
        start = 1'b1; base = b[AW-1:0]; len = l[AW:0];
        k = -1; first = -1; got = 0; aborted = 0; done_cyc = 0; done_busy = 1'b0;
        while (!got && !aborted && k < 300) begin
            @(negedge clk); #1;
            k++;
            if (k == 1) chk("busy_start", busy, l != 0);
            if (l == 0) chk("busy_len0", busy, 0);
            if (s.valid && first < 0) first = k;
            if (done) begin got = 1; done_cyc = cyc; done_busy = busy; end
            if (abort_n > 0 && popped_n >= abort_n) aborted = 1;
            @(posedge clk); #1;
            start = extra && (k == 2);
            if (start) begin base = ~base; len = 9'd3; end
        end
        if (aborted) return;
        chk("done_seen", got, 1);
        @(negedge clk); #1;
        chk("done_single", done, 0);
        chk("words_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        chk("busy_at_done", done_busy, 0);
        if (l > 0) chk("done_after_last", done_cyc, last_pop_cyc + 1);
        if (exp_first >= 0) chk("first_valid_cyc", first, exp_first);
        if (exp_done >= 0) chk("done_cyc", k, exp_done);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem_model[i] = $urandom;
        repeat (2) @(negedge clk);
        chk("rst_cenb", mem_cenb, 1);
        chk("rst_wenb", mem_wenb, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", s.valid, 0);
        chk("rst_data", s.data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk);

        run_burst(16'h10, 4, 0, 3, 7, 0, 0);
        run_burst(16'hFE, 4, 0, 3, 7, 0, 0);
        run_burst($urandom_range(0, SIZE-1), 8, 1, -1, -1, 0, 0);
        run_burst($urandom_range(0, SIZE-1), 8, 2, -1, -1, 0, 0);
        run_burst($urandom_range(0, SIZE-1), 0, 0, -1, 1, 0, 0);
        run_burst($urandom_range(0, SIZE-1), 6, 2, -1, -1, 1, 0);

        run_burst($urandom_range(0, SIZE-1), 8, 2, -1, -1, 0, 3);
        @(posedge clk); #2; rst = 1'b1; #1;
        chk("mid_rst_cenb", mem_cenb, 1);
        chk("mid_rst_wenb", mem_wenb, 1);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_valid", s.valid, 0);
        chk("mid_rst_data", s.data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        exp_q.delete(); addr_q.delete(); issued_n = 0; popped_n = 0;
        repeat (2) begin @(negedge clk); chk("rst_no_read", mem_cenb, 1); end
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) begin @(negedge clk); chk("post_rst_idle", mem_cenb, 1); end
        run_burst($urandom_range(0, SIZE-1), 2, 0, 3, 5, 0, 0);

        for (int t = 0; t < 6; t++)
            run_burst($urandom_range(0, SIZE-1), $urandom_range(1, 12), $urandom_range(0, 2), -1, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_rd_streamer.md
MEM_RD_STREAMER -- requirements
Module: mem_rd_streamer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the memory word and stream data width in bits.
REQ-002 The block SHALL have parameter SIZE, default 256, giving the memory depth in words; AW = $clog2(SIZE).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: request a burst; sampled only in IDLE.
REQ-006 The block SHALL have port base_addr_i, input, AW bits: first word address, captured with start_i.
REQ-007 The block SHALL have port len_i, input, AW+1 bits: number of words to read (0..SIZE), captured with start_i.
REQ-008 The block SHALL have port mem_cenb_o, output, 1 bit: memory enable to the SRAM, active low.
REQ-009 The block SHALL have port mem_wenb_o, output, 1 bit: memory write enable, active low; tied high (read only).
REQ-010 The block SHALL have port mem_addr_o, output, AW bits: memory read address.
REQ-011 The block SHALL have port mem_q_i, input, WIDTH bits: SRAM read data, valid one cycle after the read is issued.
REQ-012 The block SHALL have port data_o, output, WIDTH bits: stream data to the downstream array feeder.
REQ-013 The block SHALL have port valid_o, output, 1 bit: data_o holds a word.
REQ-014 The block SHALL have port ready_i, input, 1 bit: downstream accepts; a transfer occurs when valid_o && ready_i.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high from burst acceptance until completion.
REQ-016 The block SHALL have port done_o, output, 1 bit: single-cycle pulse on burst completion.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start_i with len_i>0; RUN->DRAIN after the last read is issued; DRAIN->IDLE when the last word transfers downstream.
REQ-018 start_i with len_i==0 SHALL stay in IDLE, issue no read, and pulse done_o in the following cycle.
REQ-019 start_i while busy_o is high SHALL be ignored; the captured base and length SHALL not change.
REQ-020 A read SHALL be issued (mem_cenb_o=0) in a cycle only in RUN when occupancy + pending - pop < 2, where occupancy is the output buffer count, pending is 1 if a read was issued the previous cycle, and pop = valid_o && ready_i.
REQ-021 The first read SHALL be issued the cycle after start_i is accepted, at mem_addr_o = base_addr_i.
REQ-022 The address SHALL increment by 1 per issued read and wrap from SIZE-1 to 0.
REQ-023 mem_q_i SHALL be written into the 2-entry output buffer in the cycle after each issued read, never otherwise.
REQ-024 With ready_i held high, the first valid_o SHALL appear 3 cycles after the start_i cycle, and throughput SHALL be 1 word per cycle.
REQ-025 Words SHALL be delivered in address order; no word SHALL be dropped or duplicated under any ready_i pattern.
REQ-026 data_o SHALL be stable while valid_o && !ready_i.
REQ-027 done_o SHALL pulse in the cycle after the last transfer; busy_o SHALL fall in that same cycle.
REQ-028 mem_addr_o SHALL hold its last value when mem_cenb_o=1.

Reset
REQ-029 On rst_i assertion, regardless of clock, the FSM SHALL enter IDLE and mem_cenb_o=1, mem_wenb_o=1, mem_addr_o=0, valid_o=0, data_o=0, busy_o=0, done_o=0.
REQ-030 Reset mid-burst SHALL discard buffered and pending words; no read SHALL be issued until a new start_i after reset release.

Structure
REQ-031 WIDTH/SIZE defaults and the state enum SHALL live in shared package mem_pkg.
REQ-032 The output buffer SHALL be a sub-module stream_fifo (depth 2, parameter WIDTH, flow-through disabled).

Verification
REQ-033 Reset release, start_i base=0x10 len=4, ready_i=1 -> reads at 0x10..0x13 in consecutive cycles, valid_o from cycle T+3, done_o one pulse after the 4th word.
REQ-034 base=0xFE len=4 -> addresses 0xFE,0xFF,0x00,0x01; data in that order.
REQ-035 len=8, ready_i toggling 1-0-1-0 and random -> all 8 words in order, mem_cenb_o never low with 2 words buffered and no pop.
REQ-036 len=0 -> no mem_cenb_o low, done_o pulse next cycle, busy_o stays 0.
REQ-037 start_i pulsed again during a len=6 burst -> ignored; exactly 6 words delivered.
REQ-038 rst_i asserted after 3 of 8 words -> outputs at reset values immediately, no further reads; new start_i len=2 delivers 2 correct words.
